// File: rtl/uart_tx_arb_pkg.sv
// Shared FSM encoding and index-width helper for the uart_tx_arb slice.
package uart_tx_arb_pkg;

   typedef enum logic [1:0] {
      ST_ARB       = 2'd0,
      ST_START     = 2'd1,
      ST_WAIT_BUSY = 2'd2,
      ST_WAIT_IDLE = 2'd3
   } state_t;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin picker: first request at or after i_ptr, wrapping modulo N_REQ.
module rr_pick
   import uart_tx_arb_pkg::*;
#(
   parameter  int N_REQ = 4,
   localparam int IW    = idx_w(N_REQ)
)(
   input  logic [N_REQ-1:0] i_req,
   input  logic [IW-1:0]    i_ptr,
   output logic [N_REQ-1:0] o_gnt,
   output logic [IW-1:0]    o_idx,
   output logic             o_any
);

   int w_j;

   // Scan from farthest to nearest so the closest hit to i_ptr is the last write.
   always_comb begin
      o_gnt = '0;
      o_idx = '0;
      o_any = 1'b0;
      w_j   = 0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         w_j = int'(i_ptr) + k;
         if (w_j >= N_REQ) w_j = w_j - N_REQ;
         if (i_req[w_j]) begin
            o_gnt      = '0;
            o_gnt[w_j] = 1'b1;
            o_idx      = IW'(w_j);
            o_any      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin per-message arbiter feeding one uart_tx serializer.
// Optional lock-release timeout enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arb
   import uart_tx_arb_pkg::*;
#(
   parameter  int N_REQ          = 4,
   parameter  int TIMEOUT_CYCLES = 4096,
   localparam int IW             = idx_w(N_REQ)
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [8*N_REQ-1:0] req_data,
   input  logic [N_REQ-1:0]   req_last,
   output logic [N_REQ-1:0]   req_ready,
   output logic               tx_start,
   output logic [7:0]         tx_data,
   input  logic               tx_idle,
   output logic [IW-1:0]      grant_id,
   output logic               locked,
   output logic               timeout
);

   if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
      $error("uart_tx_arb: N_REQ must be 2..8");
   end
   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("uart_tx_arb: TIMEOUT_CYCLES must be >= 2");
   end

   state_t           r_state;
   logic             r_locked;
   logic             r_last;
   logic [IW-1:0]    r_grant;
   logic [IW-1:0]    r_rr_ptr;
   logic [7:0]       r_tx_data;

   logic [N_REQ-1:0] w_owner_oh;
   logic [N_REQ-1:0] w_req;
   logic [N_REQ-1:0] w_gnt;
   logic [IW-1:0]    w_ptr;
   logic [IW-1:0]    w_sel;
   logic [IW-1:0]    w_next;
   logic             w_any;
   logic             w_to_hit;

   always_comb begin
      w_owner_oh          = '0;
      w_owner_oh[r_grant] = 1'b1;
   end

   // While locked only the owner competes; everyone else sees ready=0.
   assign w_req  = r_locked ? (req_valid & w_owner_oh) : req_valid;
   assign w_ptr  = r_locked ? r_grant : r_rr_ptr;
   assign w_next = (r_grant == IW'(N_REQ - 1)) ? '0 : r_grant + 1'b1;

   rr_pick #(.N_REQ(N_REQ)) u_pick (
      .i_req (w_req),
      .i_ptr (w_ptr),
      .o_gnt (w_gnt),
      .o_idx (w_sel),
      .o_any (w_any)
   );

   assign req_ready = (r_state == ST_ARB) ? w_gnt : '0;
   assign tx_start  = (r_state == ST_START) && tx_idle;
   assign tx_data   = r_tx_data;
   assign grant_id  = r_grant;
   assign locked    = r_locked;

`ifdef UART_TX_ARB_TIMEOUT_EN
   localparam int TW = idx_w(TIMEOUT_CYCLES);

   logic [TW-1:0] r_to_cnt;
   logic          r_timeout;
   logic          w_to_run;

   assign w_to_run = (r_state == ST_ARB) && r_locked && !req_valid[r_grant];
   assign w_to_hit = w_to_run && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
   assign timeout  = r_timeout;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_to_cnt  <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= w_to_hit;
         if (!w_to_run || w_to_hit) r_to_cnt <= '0;
         else                       r_to_cnt <= r_to_cnt + 1'b1;
      end
   end
`else
   assign w_to_hit = 1'b0;
   assign timeout  = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_ARB;
         r_locked  <= 1'b0;
         r_last    <= 1'b0;
         r_grant   <= '0;
         r_rr_ptr  <= '0;
         r_tx_data <= 8'h00;
      end else begin
         case (r_state)
            ST_ARB: begin
               if (w_any) begin
                  r_tx_data <= req_data[8*w_sel +: 8];
                  r_last    <= req_last[w_sel];
                  r_grant   <= w_sel;
                  r_locked  <= 1'b1;
                  r_state   <= ST_START;
               end else if (w_to_hit) begin
                  r_locked <= 1'b0;
                  r_rr_ptr <= w_next;
               end
            end
            // Holds off until the serializer is idle, e.g. a frame left over from reset.
            ST_START:     if (tx_idle)  r_state <= ST_WAIT_BUSY;
            ST_WAIT_BUSY: if (!tx_idle) r_state <= ST_WAIT_IDLE;
            ST_WAIT_IDLE: begin
               if (tx_idle) begin
                  if (r_last) begin
                     r_locked <= 1'b0;
                     r_rr_ptr <= w_next;
                  end
                  r_state <= ST_ARB;
               end
            end
            default: r_state <= ST_ARB;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb with a behavioural serializer and line decoder.
module tb_uart_tx_arb;

   localparam int BIT = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_last;
   logic [3:0]  req_ready;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        tx_idle;
   logic [1:0]  grant_id;
   logic        locked;
   logic        timeout;

   int checks = 0;
   int errors = 0;
   logic [7:0] sbq[$];

   always #5 clk = ~clk;

   uart_tx_arb #(.N_REQ(4), .TIMEOUT_CYCLES(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_last  (req_last),
      .req_ready (req_ready),
      .tx_start  (tx_start),
      .tx_data   (tx_data),
      .tx_idle   (tx_idle),
      .grant_id  (grant_id),
      .locked    (locked),
      .timeout   (timeout)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Serializer model: not reset by rst_n, idle drops the cycle after start.
   logic       m_busy  = 1'b0;
   logic       m_dirty = 1'b0;
   int         m_cnt   = 0;
   logic [7:0] m_sh    = 8'h00;
   logic       line;

   assign tx_idle = !m_busy;
   assign line = !m_busy ? 1'b1 :
                 (m_cnt < BIT) ? 1'b0 :
                 (m_cnt < 9*BIT) ? m_sh[(m_cnt-BIT)/BIT] : 1'b1;

   always @(posedge clk) begin
      if (!rst_n) m_dirty <= 1'b1;
      if (tx_start) check("start_while_idle", {31'd0, m_busy}, 32'd0);
      if (!m_busy && tx_start) begin
         m_busy  <= 1'b1;
         m_cnt   <= 0;
         m_sh    <= tx_data;
         m_dirty <= 1'b0;
      end else if (m_busy) begin
         if (m_cnt == 10*BIT - 1) begin
            m_busy <= 1'b0;
            if (!m_dirty) check("tx_data_stable", {24'd0, tx_data}, {24'd0, m_sh});
         end else begin
            m_cnt <= m_cnt + 1;
         end
      end
   end

   initial begin : decoder
      logic [7:0] b;
      forever begin
         @(negedge clk);
         if (line === 1'b0) begin
            repeat (BIT/2) @(negedge clk);
            for (int k = 0; k < 8; k++) begin
               repeat (BIT) @(negedge clk);
               b[k] = line;
            end
            repeat (BIT) @(negedge clk);
            check("stop_bit", {31'd0, line}, 32'd1);
            if (sbq.size() == 0) check("byte_expected", 32'd0, 32'd1);
            else                 check("line_byte", {24'd0, b}, {24'd0, sbq.pop_front()});
         end
      end
   end

   // Called right after a posedge; returns right after the posedge that took the byte.
   task automatic xfer(input int i, input logic [7:0] d, input logic l, input logic drop);
      logic found;
      req_valid[i]       = 1'b1;
      req_data[8*i +: 8] = d;
      req_last[i]        = l;
      found = 1'b0;
      for (int c = 0; c < 400 && !found; c++) begin
         @(negedge clk);
         if (req_ready[i]) found = 1'b1;
      end
      check("accept_seen", {31'd0, found}, 32'd1);
      check("ready_onehot", {28'd0, req_ready}, 32'd1 << i);
      if (found) sbq.push_back(d);
      @(posedge clk); #1;
      if (drop) req_valid[i] = 1'b0;
   endtask

   task automatic wait_unlock();
      logic found;
      found = 1'b0;
      for (int c = 0; c < 400 && !found; c++) begin
         @(negedge clk);
         if (!locked) found = 1'b1;
      end
      check("unlock_seen", {31'd0, found}, 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic check_reset_vals();
      check("rst_ready",    {28'd0, req_ready}, 32'd0);
      check("rst_tx_start", {31'd0, tx_start},  32'd0);
      check("rst_tx_data",  {24'd0, tx_data},   32'd0);
      check("rst_grant",    {30'd0, grant_id},  32'd0);
      check("rst_locked",   {31'd0, locked},    32'd0);
      check("rst_timeout",  {31'd0, timeout},   32'd0);
   endtask

   logic watch2 = 1'b0;
   int   bad2   = 0;
   always @(negedge clk) if (watch2 && req_ready[2]) bad2++;

   initial begin : stim
      logic found;
      int   e;
      rst_n     = 1'b0;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_vals();
      @(posedge clk); #1;
      rst_n = 1'b1;

      // single-byte message from requester 0, latency and lock release
      xfer(0, 8'h41, 1'b1, 1'b1);
      @(negedge clk);
      check("t1_start",  {31'd0, tx_start}, 32'd1);
      check("t1_data",   {24'd0, tx_data},  32'h41);
      check("t1_locked", {31'd0, locked},   32'd1);
      check("t1_grant",  {30'd0, grant_id}, 32'd0);
      check("t1_ready0", {28'd0, req_ready}, 32'd0);
      @(negedge clk);
      check("t1_pulse",  {31'd0, tx_start}, 32'd0);
      wait_unlock();

      // 3-byte message from requester 1 while requester 2 waits
      req_valid[2]  = 1'b1;
      req_data[23:16] = 8'hAA;
      req_last[2]   = 1'b1;
      watch2 = 1'b1;
      xfer(1, 8'h10, 1'b0, 1'b0);
      xfer(1, 8'h20, 1'b0, 1'b0);
      xfer(1, 8'h30, 1'b1, 1'b1);
      watch2 = 1'b0;
      check("t2_no_ready2", bad2, 32'd0);
      xfer(2, 8'hAA, 1'b1, 1'b1);
      wait_unlock();

      // bring rr_ptr back to 0, then all four contend
      xfer(3, 8'h33, 1'b1, 1'b1);
      wait_unlock();
      req_data  = 32'hC3C2C1C0;
      req_last  = 4'hF;
      req_valid = 4'hF;
      for (int k = 0; k < 5; k++) begin
         e = k % 4;
         found = 1'b0;
         for (int c = 0; c < 400 && !found; c++) begin
            @(negedge clk);
            if (|req_ready) found = 1'b1;
         end
         check("t3_accept_seen", {31'd0, found}, 32'd1);
         check("t3_order", {28'd0, req_ready}, 32'd1 << e);
         if (found) sbq.push_back(req_data[8*e +: 8]);
         @(posedge clk); #1;
         if (k != 0) req_valid[e] = 1'b0;
         @(negedge clk);
         check("t3_grant", {30'd0, grant_id}, e);
      end
      wait_unlock();

      // captured byte survives a change of req_data
      xfer(1, 8'h5A, 1'b1, 1'b1);
      req_data[15:8] = 8'hFF;
      @(negedge clk);
      check("t4_start", {31'd0, tx_start}, 32'd1);
      repeat (20) @(negedge clk);
      check("t4_hold", {24'd0, tx_data}, 32'h5A);
      wait_unlock();

      // reset in the middle of a frame
      xfer(2, 8'h55, 1'b1, 1'b1);
      repeat (30) @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      check_reset_vals();
      @(posedge clk); #1;
      rst_n = 1'b1;
      xfer(0, 8'h66, 1'b1, 1'b1);
      found = 1'b0;
      for (int c = 0; c < 400 && !found; c++) begin
         @(negedge clk);
         if (tx_start) found = 1'b1;
      end
      check("t5_start_seen", {31'd0, found}, 32'd1);
      check("t5_start_idle", {31'd0, tx_idle}, 32'd1);
      wait_unlock();

      // owner abandons its message
      req_valid[0] = 1'b0;
      xfer(3, 8'hB3, 1'b0, 1'b1);
      found = 1'b0;
      for (int c = 0; c < 400 && !found; c++) begin
         @(negedge clk);
         if (!tx_idle) found = 1'b1;
      end
      found = 1'b0;
      for (int c = 0; c < 400 && !found; c++) begin
         @(negedge clk);
         if (tx_idle) found = 1'b1;
      end
      check("t6_frame_done", {31'd0, found}, 32'd1);
      req_valid[0]  = 1'b1;
      req_data[7:0] = 8'h0B;
      req_last[0]   = 1'b1;
`ifdef UART_TX_ARB_TIMEOUT_EN
      e = 0;
      found = 1'b0;
      for (int c = 1; c < 100 && !found; c++) begin
         @(negedge clk);
         if (timeout) begin
            found = 1'b1;
            e = c;
         end
      end
      check("t6_timeout_seen", {31'd0, found}, 32'd1);
      check("t6_timeout_time", e, 32'd17);
      check("t6_unlocked", {31'd0, locked}, 32'd0);
      @(negedge clk);
      check("t6_pulse", {31'd0, timeout}, 32'd0);
      @(posedge clk); #1;
      xfer(0, 8'h0B, 1'b1, 1'b1);
      wait_unlock();
`else
      repeat (60) @(negedge clk);
      check("t6_held", {31'd0, locked}, 32'd1);
      check("t6_no_ready", {28'd0, req_ready}, 32'd0);
      check("t6_no_timeout", {31'd0, timeout}, 32'd0);
      @(posedge clk); #1;
      req_valid = '0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
`endif

      found = 1'b0;
      for (int c = 0; c < 2000 && !found; c++) begin
         @(negedge clk);
         if (sbq.size() == 0) found = 1'b1;
      end
      repeat (2*BIT) @(negedge clk);
      check("sb_drained", sbq.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
